// File: rtl/rx_code_group_decoder_if.sv
// Code-group receive bus: 10-bit group in, decoded byte plus status out.
// The decoder takes the slave view; whoever feeds it and consumes its results takes the master view.
interface rx_code_group_decoder_if;
  logic [9:0] code_group;
  logic       cg_valid;
  logic [7:0] rxd;
  logic       rx_is_k;
  logic       rx_valid;
  logic       code_err;
  logic       disp_err;
  logic       rd;

  modport master (
    output code_group, cg_valid,
    input  rxd, rx_is_k, rx_valid, code_err, disp_err, rd
  );

  modport slave (
    input  code_group, cg_valid,
    output rxd, rx_is_k, rx_valid, code_err, disp_err, rd
  );
endinterface

// File: rtl/rx_code_group_decoder.sv
// 1000BASE-X receive 8B/10B decoder: stage 1 table-decodes and classifies sub-blocks,
// stage 2 checks/updates running disparity and registers the outputs.
module rx_code_group_decoder (
  input  logic                    clk,
  input  logic                    mr_main_reset,
  rx_code_group_decoder_if.slave  cg
);

  // {ok, EDCBA}; K28 patterns decode to 28 like data, K-ness is tracked separately
  function automatic logic [5:0] dec_6b(input logic [5:0] c);
    logic [5:0] r;
    r = 6'b000000;
    case (c)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      6'b001111, 6'b110000: r = {1'b1, 5'd28};
      default:              r = 6'b000000;
    endcase
    return r;
  endfunction

  // {ok, HGF} for data groups; 0111/1000 (alternate 7) accepted anywhere
  function automatic logic [3:0] dec_4b_data(input logic [3:0] c);
    logic [3:0] r;
    r = 4'b0000;
    case (c)
      4'b0100, 4'b1011:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = 4'b0000;
    endcase
    return r;
  endfunction

  // {ok, HGF} after K28; input is normalised to the 001111 polarity (inverted after 110000)
  function automatic logic [3:0] dec_4b_k28(input logic [3:0] c);
    logic [3:0] r;
    r = 4'b0000;
    case (c)
      4'b0100, 4'b1011: r = {1'b1, 3'd0};
      4'b1001:          r = {1'b1, 3'd1};
      4'b0101:          r = {1'b1, 3'd2};
      4'b0011, 4'b1100: r = {1'b1, 3'd3};
      4'b0010, 4'b1101: r = {1'b1, 3'd4};
      4'b1010:          r = {1'b1, 3'd5};
      4'b0110:          r = {1'b1, 3'd6};
      4'b1000, 4'b0111: r = {1'b1, 3'd7};
      default:          r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ones_6b(input logic [5:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, c[i]};
    return n;
  endfunction

  function automatic logic [2:0] ones_4b(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, c[i]};
    return n;
  endfunction

  logic [5:0] six_s;
  logic [3:0] four_s;
  logic [5:0] d6_s;
  logic [3:0] d4_s;
  logic       is_k28_s;
  logic       is_kx7_s;

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_byte_q,  s1_byte_d;
  logic       s1_k_q,     s1_k_d;
  logic       s1_cerr_q,  s1_cerr_d;
  logic       s1_p6_q,    s1_p6_d;
  logic       s1_n6_q,    s1_n6_d;
  logic       s1_p4_q,    s1_p4_d;
  logic       s1_n4_q,    s1_n4_d;

  logic [7:0] rxd_q,      rxd_d;
  logic       rx_is_k_q,  rx_is_k_d;
  logic       rx_valid_q, rx_valid_d;
  logic       code_err_q, code_err_d;
  logic       disp_err_q, disp_err_d;
  logic       rd_q,       rd_d;
  logic       rd_mid_s;

  assign six_s  = cg.code_group[9:4];
  assign four_s = cg.code_group[3:0];

  // Stage 1: table decode, K detection and sub-block disparity class
  always_comb begin
    d6_s     = dec_6b(six_s);
    is_k28_s = (six_s == 6'b001111) || (six_s == 6'b110000);
    is_kx7_s = ((six_s == 6'b111010) || (six_s == 6'b000101) ||
                (six_s == 6'b110110) || (six_s == 6'b001001) ||
                (six_s == 6'b101110) || (six_s == 6'b010001) ||
                (six_s == 6'b011110) || (six_s == 6'b100001)) &&
               ((four_s == 4'b1000) || (four_s == 4'b0111));
    if (is_k28_s) begin
      d4_s = dec_4b_k28(four_s ^ {4{six_s == 6'b110000}});
    end else begin
      d4_s = dec_4b_data(four_s);
    end
    s1_valid_d = cg.cg_valid;
    if (cg.cg_valid) begin
      s1_byte_d = {d4_s[2:0], d6_s[4:0]};
      s1_k_d    = is_k28_s || is_kx7_s;
      s1_cerr_d = !d6_s[5] || !d4_s[3];
      s1_p6_d   = (ones_6b(six_s) == 3'd4) || (six_s == 6'b111000);
      s1_n6_d   = (ones_6b(six_s) == 3'd2) || (six_s == 6'b000111);
      s1_p4_d   = (ones_4b(four_s) == 3'd3) || (four_s == 4'b1100);
      s1_n4_d   = (ones_4b(four_s) == 3'd1) || (four_s == 4'b0011);
    end else begin
      s1_byte_d = s1_byte_q;
      s1_k_d    = s1_k_q;
      s1_cerr_d = s1_cerr_q;
      s1_p6_d   = s1_p6_q;
      s1_n6_d   = s1_n6_q;
      s1_p4_d   = s1_p4_q;
      s1_n4_d   = s1_n4_q;
    end
  end

  // Stage 2: disparity check against entering rd, then rd after the 6b block
  always_comb begin
    rxd_d      = rxd_q;
    rx_is_k_d  = rx_is_k_q;
    rx_valid_d = 1'b0;
    code_err_d = 1'b0;
    disp_err_d = 1'b0;
    rd_d       = rd_q;
    rd_mid_s   = rd_q;
    if (s1_valid_q) begin
      rx_valid_d = 1'b1;
      if (s1_cerr_q) begin
        code_err_d = 1'b1;
        rxd_d      = 8'h00;
        rx_is_k_d  = 1'b0;
      end else begin
        rd_mid_s   = s1_p6_q ? 1'b1 : (s1_n6_q ? 1'b0 : rd_q);
        rd_d       = s1_p4_q ? 1'b1 : (s1_n4_q ? 1'b0 : rd_mid_s);
        disp_err_d = (s1_p6_q && rd_q) || (s1_n6_q && !rd_q) ||
                     (s1_p4_q && rd_mid_s) || (s1_n4_q && !rd_mid_s);
        rxd_d      = s1_byte_q;
        rx_is_k_d  = s1_k_q;
      end
    end else begin
      rx_valid_d = 1'b0;
    end
  end

  // Pipeline and output registers; reset drops any groups in flight
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      s1_valid_q <= 1'b0;
      s1_byte_q  <= 8'h00;
      s1_k_q     <= 1'b0;
      s1_cerr_q  <= 1'b0;
      s1_p6_q    <= 1'b0;
      s1_n6_q    <= 1'b0;
      s1_p4_q    <= 1'b0;
      s1_n4_q    <= 1'b0;
      rxd_q      <= 8'h00;
      rx_is_k_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      code_err_q <= 1'b0;
      disp_err_q <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_byte_q  <= s1_byte_d;
      s1_k_q     <= s1_k_d;
      s1_cerr_q  <= s1_cerr_d;
      s1_p6_q    <= s1_p6_d;
      s1_n6_q    <= s1_n6_d;
      s1_p4_q    <= s1_p4_d;
      s1_n4_q    <= s1_n4_d;
      rxd_q      <= rxd_d;
      rx_is_k_q  <= rx_is_k_d;
      rx_valid_q <= rx_valid_d;
      code_err_q <= code_err_d;
      disp_err_q <= disp_err_d;
      rd_q       <= rd_d;
    end
  end

  assign cg.rxd      = rxd_q;
  assign cg.rx_is_k  = rx_is_k_q;
  assign cg.rx_valid = rx_valid_q;
  assign cg.code_err = code_err_q;
  assign cg.disp_err = disp_err_q;
  assign cg.rd       = rd_q;

endmodule

// File: tb/tb_rx_code_group_decoder.sv
// Directed bench for rx_code_group_decoder: table of code-groups with hand-decoded results,
// each checked two cycles after it is driven, plus reset and mid-stream reset checks.
module tb_rx_code_group_decoder;

  logic clk;
  logic mr_main_reset;
  int   checks;
  int   failures;

  rx_code_group_decoder_if bus ();

  rx_code_group_decoder dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .cg            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word layout: {rx_valid, rx_is_k, code_err, disp_err, rd, rxd[7:0]}
  logic [9:0]  tv_cg  [0:39];
  logic        tv_v   [0:39];
  logic [12:0] tv_exp [0:39];
  int          n_vec;

  function automatic logic [12:0] exp_of(input logic v, input logic k, input logic ce,
                                         input logic de, input logic r, input logic [7:0] b);
    return {v, k, ce, de, r, b};
  endfunction

  function automatic logic [12:0] observed();
    return {bus.rx_valid, bus.rx_is_k, bus.code_err, bus.disp_err, bus.rd, bus.rxd};
  endfunction

  task automatic add_vec(input logic [9:0] c, input logic v, input logic [12:0] e);
    tv_cg[n_vec]  = c;
    tv_v[n_vec]   = v;
    tv_exp[n_vec] = e;
    n_vec++;
  endtask

  task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h (v,k,ce,de,rd,rxd)", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    n_vec          = 0;
    mr_main_reset  = 1'b0;
    bus.code_group = 10'h000;
    bus.cg_valid   = 1'b0;

    // /I2/ ordered set eight times, starting from rd = 0
    for (int p = 0; p < 8; p++) begin
      add_vec(10'h0FA, 1'b1, exp_of(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBC));
      add_vec(10'h245, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h50));
    end
    add_vec(10'h2AA, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB5));
    add_vec(10'h305, 1'b1, exp_of(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hBC));
    add_vec(10'h3FF, 1'b1, exp_of(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    add_vec(10'h000, 1'b0, exp_of(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    add_vec(10'h0FA, 1'b1, exp_of(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBC));
    add_vec(10'h000, 1'b0, exp_of(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBC));
    add_vec(10'h245, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h50));
    add_vec(10'h3A8, 1'b1, exp_of(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF7));
    add_vec(10'h0F4, 1'b1, exp_of(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C));
    add_vec(10'h381, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE7));
    add_vec(10'h31C, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h63));
    add_vec(10'h0F1, 1'b1, exp_of(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
    add_vec(10'h05E, 1'b1, exp_of(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF7));

    repeat (3) @(negedge clk);
    mr_main_reset = 1'b1;
    @(negedge clk);
    check_eq("reset_state", observed(), 13'h0000);

    for (int i = 0; i < n_vec + 2; i++) begin
      @(negedge clk);
      if (i >= 2) check_eq($sformatf("vec%0d_cg%h", i - 2, tv_cg[i - 2]), observed(), tv_exp[i - 2]);
      if (i < n_vec) begin
        bus.code_group = tv_cg[i];
        bus.cg_valid   = tv_v[i];
      end else begin
        bus.code_group = 10'h000;
        bus.cg_valid   = 1'b0;
      end
    end

    // Mid-stream reset: one group in stage 1, another on the input
    @(negedge clk);
    bus.code_group = 10'h0FA;
    bus.cg_valid   = 1'b1;
    @(negedge clk);
    bus.code_group = 10'h245;
    bus.cg_valid   = 1'b1;
    #2;
    mr_main_reset = 1'b0;
    #1;
    check_eq("reset_async_clear", observed(), 13'h0000);
    bus.cg_valid = 1'b0;
    repeat (2) @(negedge clk);
    mr_main_reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_eq($sformatf("post_reset_idle%0d", j), observed(), 13'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
